// File: rtl/bcd_div_pkg.sv
// Shared types and helpers for the serial BCD divisibility checker.
package bcd_div_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic is_bcd(input bcd_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_mod_step.sv
// One step of the running remainder: (rem*10 + digit) mod div.
// Relies on rem < div, which keeps the quotient below 16, so four
// restoring compare/subtract stages (div<<3 .. div<<0) always finish the
// reduction without a divide operator.
module bcd_mod_step
  import bcd_div_pkg::*;
(
  input  bcd_t rem,
  input  bcd_t digit,
  input  bcd_t div,
  output bcd_t rem_next
);

  logic [7:0] w_work;
  logic [7:0] w_sub;

  // Form rem*10+digit, then strip multiples of div from the largest down
  always_comb begin
    w_work = {1'b0, rem, 3'b000} + {3'b000, rem, 1'b0} + {4'b0000, digit};
    w_sub  = 8'd0;
    for (int k = 3; k >= 0; k--) begin
      w_sub = {4'b0000, div} << k;
      if (w_work >= w_sub) begin
        w_work = w_work - w_sub;
      end
    end
    rem_next = w_work[3:0];
  end

endmodule

// File: rtl/bcd_divisibility_checker.sv
// Serial BCD divisibility checker: takes NUM_DIGITS BCD digits MSD-first and
// reports whether the latched divisor digit divides the number.
// Optional feature macro: BCD_DIV_REMAINDER_EN adds the remainder[3:0] output.
module bcd_divisibility_checker
  import bcd_div_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] divisor,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic       digit_ready,
  output logic       busy,
  output logic       done,
  output logic       is_divider,
  output logic       error
`ifdef BCD_DIV_REMAINDER_EN
  ,
  output logic [3:0] remainder
`endif
);

  state_t           r_state;
  state_t           w_nextState;
  bcd_t             r_div;
  bcd_t             r_rem;
  logic [CNT_W-1:0] r_count;
  logic             r_isDivider;
  logic             r_error;
  bcd_t             w_remNext;
  logic             w_divValid;
  logic             w_startRun;
  logic             w_accept;
  logic             w_lastDigit;

  assign w_divValid  = (divisor != 4'd0) && is_bcd(divisor);
  assign w_startRun  = (r_state == IDLE) && start;
  assign w_accept    = (r_state == RUN) && digit_valid;
  assign w_lastDigit = w_accept && (r_count == CNT_W'(NUM_DIGITS - 1));

  assign is_divider = r_isDivider;
  assign error      = r_error;

  bcd_mod_step u_modStep (
    .rem      (r_rem),
    .digit    (digit),
    .div      (r_div),
    .rem_next (w_remNext)
  );

  // State register; reset aborts any run without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake/status outputs decoded from the current state
  always_comb begin
    w_nextState = r_state;
    digit_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = w_divValid ? RUN : DONE;
        end
      end
      RUN: begin
        digit_ready = 1'b1;
        busy        = 1'b1;
        if (w_lastDigit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Running remainder, digit count and sticky result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= '0;
      r_rem       <= '0;
      r_count     <= '0;
      r_isDivider <= 1'b0;
      r_error     <= 1'b0;
    end else if (w_startRun) begin
      r_div       <= divisor;
      r_rem       <= '0;
      r_count     <= '0;
      r_isDivider <= 1'b0;
      r_error     <= !w_divValid;
    end else if (w_accept) begin
      r_rem   <= w_remNext;
      r_count <= r_count + 1'b1;
      if (!is_bcd(digit)) begin
        r_error <= 1'b1;
      end
      if (w_lastDigit) begin
        r_isDivider <= (w_remNext == 4'd0) && !r_error && is_bcd(digit);
      end
    end
  end

`ifdef BCD_DIV_REMAINDER_EN
  bcd_t r_remOut;

  assign remainder = r_remOut;

  // Final remainder captured as the run completes; zero whenever the run errored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remOut <= '0;
    end else if (w_startRun && !w_divValid) begin
      r_remOut <= '0;
    end else if (w_lastDigit) begin
      r_remOut <= (r_error || !is_bcd(digit)) ? 4'd0 : w_remNext;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_divisibility_checker.sv
// Bench for bcd_divisibility_checker (NUM_DIGITS=3): table of runs plus
// hand-written reset/abort sequences, results checked through a scoreboard.
// Optional feature macro: BCD_DIV_REMAINDER_EN also checks remainder.
module tb_bcd_divisibility_checker;

  typedef struct {
    logic [3:0] div;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    int         gap;
    bit         startMidRun;
    logic       expIsDiv;
    logic       expErr;
    logic [3:0] expRem;
  } vec_t;

  typedef struct {
    logic       isDiv;
    logic       err;
    logic [3:0] rem;
    int         doneCyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] divisor = 4'd0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_ready;
  logic       busy;
  logic       done;
  logic       is_divider;
  logic       error;
`ifdef BCD_DIV_REMAINDER_EN
  logic [3:0] remainder;
`endif

  int   cyc = 0;
  int   nCompared = 0;
  int   nMismatched = 0;
  exp_t sbQ[$];
  vec_t vecs[12];

  bcd_divisibility_checker #(.NUM_DIGITS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .divisor     (divisor),
    .digit_valid (digit_valid),
    .digit       (digit),
    .digit_ready (digit_ready),
    .busy        (busy),
    .done        (done),
    .is_divider  (is_divider),
    .error       (error)
`ifdef BCD_DIV_REMAINDER_EN
    ,
    .remainder   (remainder)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("done_cycle", cyc, e.doneCyc);
        checkOutput("is_divider", int'(is_divider), int'(e.isDiv));
        checkOutput("error", int'(error), int'(e.err));
        checkOutput("busy_at_done", int'(busy), 1);
`ifdef BCD_DIV_REMAINDER_EN
        checkOutput("remainder", int'(remainder), int'(e.rem));
`endif
      end
    end
  end

  // Drives one run starting in an IDLE cycle; returns #1 after the edge
  // following the done cycle, with results checked as held in IDLE.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   budget;
    logic [3:0] ds[3];
    bit   divOk;
    ds[0] = v.d0;
    ds[1] = v.d1;
    ds[2] = v.d2;
    divOk = (v.div != 4'd0) && (v.div <= 4'd9);
    e.isDiv   = v.expIsDiv;
    e.err     = v.expErr;
    e.rem     = v.expRem;
    e.doneCyc = cyc + (divOk ? (4 + 2 * v.gap) : 1);
    sbQ.push_back(e);
    start   = 1'b1;
    divisor = v.div;
    @(posedge clk); #1;
    start = 1'b0;
    if (divOk) begin
      for (int i = 0; i < 3; i++) begin
        digit_valid = 1'b1;
        digit       = ds[i];
        @(posedge clk); #1;
        digit_valid = 1'b0;
        if (i < 2) begin
          for (int g = 0; g < v.gap; g++) begin
            if (v.startMidRun && g == 0) begin
              start   = 1'b1;
              divisor = 4'd2;
            end
            @(posedge clk); #1;
            start   = 1'b0;
            divisor = v.div;
          end
        end
      end
    end else begin
      checkOutput("digit_ready_bad_div", int'(digit_ready), 0);
    end
    budget = 20;
    while (sbQ.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    if (sbQ.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL done_timeout: got no done expected done by cycle %0d", e.doneCyc);
      sbQ.delete();
    end
    checkOutput("busy_after_done", int'(busy), 0);
    checkOutput("done_width", int'(done), 0);
    checkOutput("is_divider_held", int'(is_divider), int'(v.expIsDiv));
    checkOutput("error_held", int'(error), int'(v.expErr));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_digit_ready"}, int'(digit_ready), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_is_divider"}, int'(is_divider), 0);
    checkOutput({tag, "_error"}, int'(error), 0);
  endtask

  initial begin
    vec_t v;
    //           div    d0     d1     d2     gap mid  isDiv err   rem
    vecs[0]  = '{4'd4, 4'd1, 4'd2, 4'd4, 0, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[1]  = '{4'd7, 4'd9, 4'd9, 4'd9, 0, 1'b0, 1'b0, 1'b0, 4'd5};
    vecs[2]  = '{4'd0, 4'd1, 4'd1, 4'd1, 0, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[3]  = '{4'd3, 4'd1, 4'hA, 4'd2, 0, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[4]  = '{4'd9, 4'd9, 4'd9, 4'd9, 2, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[5]  = '{4'hC, 4'd3, 4'd3, 4'd3, 0, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[6]  = '{4'd1, 4'd0, 4'd0, 4'd0, 0, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[7]  = '{4'd8, 4'd7, 4'd3, 4'd6, 0, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[8]  = '{4'd6, 4'd5, 4'd0, 4'd3, 1, 1'b0, 1'b0, 1'b0, 4'd5};
    vecs[9]  = '{4'd9, 4'd8, 4'd7, 4'd6, 0, 1'b0, 1'b0, 1'b0, 4'd3};
    vecs[10] = '{4'd2, 4'd9, 4'd9, 4'hF, 0, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[11] = '{4'd5, 4'd4, 4'd9, 4'd5, 0, 1'b0, 1'b1, 1'b0, 4'd0};

    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
    end

    // Abort a run (already flagged in error) with reset after two digits
    start   = 1'b1;
    divisor = 4'd3;
    @(posedge clk); #1;
    start       = 1'b0;
    digit_valid = 1'b1;
    digit       = 4'hA;
    @(posedge clk); #1;
    digit = 4'd2;
    @(posedge clk); #1;
    digit_valid = 1'b0;
    checkOutput("error_before_abort", int'(error), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkAllZero("abort");
    repeat (6) @(posedge clk);
    #1;

    v = '{4'd5, 4'd1, 4'd0, 4'd5, 0, 1'b0, 1'b1, 1'b0, 4'd0};
    applyStimulus(v);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_empty", sbQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
